// File: rtl/acondicionador_sensores.sv
// acondicionador_sensores
// Sensor front-end for the coffee-bean classifier. The raw bean-presence,
// size, weight and colour detector lines are synchronised and debounced.
// Once the bean has been present for a settling window, one coherent
// snapshot of the three sensors is captured and held for the classifier.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous reset, active low
//   bean_present_raw  raw bean-presence detector (asynchronous)
//   tamano_raw        raw size detector (asynchronous)
//   peso_raw          raw weight detector (asynchronous)
//   color_raw         raw colour detector (asynchronous)
//   sensor_tamano     captured size bit, held until the next capture
//   sensor_peso       captured weight bit, held until the next capture
//   sensor_color      captured colour bit, held until the next capture
//   muestra_valida    one-cycle strobe in the cycle after a capture edge
//   ocupado           high whenever the sequencer is not idle
module acondicionador_sensores #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic bean_present_raw,
    input  logic tamano_raw,
    input  logic peso_raw,
    input  logic color_raw,
    output logic sensor_tamano,
    output logic sensor_peso,
    output logic sensor_color,
    output logic muestra_valida,
    output logic ocupado
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    // Terminal values are one below the limit: the limit is reached on the
    // edge that would increment past them, and that edge takes the action.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ESPERA = 2'd1,
        LIBERA = 2'd2
    } state_t;

    // Bit order everywhere: [3] bean, [2] tamano, [1] peso, [0] color.
    logic [3:0]      w_raw;
    logic [3:0]      r_sync_p0;
    logic [3:0]      r_sync_p1;
    logic [3:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [4];

    state_t          r_state;
    state_t          w_state_next;
    logic [ST_W-1:0] r_settle_cnt;
    logic [ST_W-1:0] w_settle_next;
    logic            w_capture;
    logic            w_bean;
    logic [2:0]      r_sensors;
    logic            r_valid;

    assign w_raw  = {bean_present_raw, tamano_raw, peso_raw, color_raw};
    assign w_bean = r_db[3];

    // Stage p0/p1: two-flop synchronisers for the asynchronous detector lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= w_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Debounce stage: a line must disagree with its debounced value for
    // DEBOUNCE_CYCLES consecutive samples before the debounced value flips.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync_p1[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= ~r_db[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Capture sequencer: state register and settle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
        end
    end

    // Bean absence is tested before the settle expiry so that a bean
    // leaving on the expiry edge aborts instead of capturing.
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_bean) begin
                    w_state_next  = ESPERA;
                    w_settle_next = '0;
                end
            end
            ESPERA: begin
                if (!w_bean) begin
                    w_state_next = IDLE;
                end else if (r_settle_cnt == ST_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = LIBERA;
                end else begin
                    w_settle_next = r_settle_cnt + 1'b1;
                end
            end
            LIBERA: begin
                if (!w_bean) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output stage: snapshot of the debounced sensors and the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sensors <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_sensors <= r_db[2:0];
            end
        end
    end

    assign sensor_tamano  = r_sensors[2];
    assign sensor_peso    = r_sensors[1];
    assign sensor_color   = r_sensors[0];
    assign muestra_valida = r_valid;
    assign ocupado        = (r_state != IDLE);

endmodule
